// File: rtl/periph_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : periph_tx_arbiter_if
// Description : Bundle of the peripheral-FIFO side and FT601-controller side
//               signals of the TX arbiter.
//               master : arbiter view (drives pops, data, id, busy)
//               slave  : environment view (FIFOs + FT601 controller)
// Signals     : periph_enable, periph_not_empty, periph_data, periph_rd,
//               periph_data_available, read_periph_data, out_data,
//               out_periph_id, busy
// Revision    : 1.0  initial release
// ============================================================================
interface periph_tx_arbiter_if #(
  parameter int NUM_PERIPHS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = $clog2(NUM_PERIPHS)
);
  logic [NUM_PERIPHS-1:0]            periph_enable;
  logic [NUM_PERIPHS-1:0]            periph_not_empty;
  logic [NUM_PERIPHS*DATA_WIDTH-1:0] periph_data;
  logic [NUM_PERIPHS-1:0]            periph_rd;
  logic                              periph_data_available;
  logic                              read_periph_data;
  logic [DATA_WIDTH-1:0]             out_data;
  logic [ID_WIDTH-1:0]               out_periph_id;
  logic                              busy;

  modport master (
    input  periph_enable,
    input  periph_not_empty,
    input  periph_data,
    input  read_periph_data,
    output periph_rd,
    output periph_data_available,
    output out_data,
    output out_periph_id,
    output busy
  );

  modport slave (
    output periph_enable,
    output periph_not_empty,
    output periph_data,
    output read_periph_data,
    input  periph_rd,
    input  periph_data_available,
    input  out_data,
    input  out_periph_id,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/periph_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : periph_tx_arbiter
// Description : Round-robin arbiter sharing the single USB TX path among
//               NUM_PERIPHS first-word-fall-through peripheral FIFOs. A grant
//               is held for at most MAX_BURST pops or until the granted
//               requester drops, then one idle ARB cycle re-arbitrates.
// Ports       : clk    - system clock, rising edge
//               rst    - synchronous active-high reset
//               tx_if  - periph_tx_arbiter_if.master (FIFO heads/pops,
//                        FT601 valid/pop handshake, granted id, busy)
// Revision    : 1.0  initial release
// ============================================================================
module periph_tx_arbiter #(
  parameter int NUM_PERIPHS = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 16,
  parameter int ID_WIDTH    = $clog2(NUM_PERIPHS)
) (
  input  logic                clk,
  input  logic                rst,
  periph_tx_arbiter_if.master tx_if
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID_RST = ID_WIDTH'(NUM_PERIPHS - 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;

  logic [NUM_PERIPHS-1:0] req;
  logic [DATA_WIDTH-1:0]  words [NUM_PERIPHS];
  logic [ID_WIDTH-1:0]    next_id;
  logic                   next_found;
  logic                   avail;
  logic                   pop;
  logic [NUM_PERIPHS-1:0] rd;
  logic [DATA_WIDTH-1:0]  data_mux;
  logic [ID_WIDTH-1:0]    id_out;
  logic                   busy;

  assign req = tx_if.periph_enable & tx_if.periph_not_empty;

  generate
    for (genvar g = 0; g < NUM_PERIPHS; g++) begin : g_unpack
      assign words[g] = tx_if.periph_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin pick: scan last_id+1, last_id+2, ... with wrap, so the most
  // recently served peripheral is considered last.
  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] cand;
    next_found = 1'b0;
    next_id    = '0;
    idx        = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_PERIPHS; k++) begin
      idx  = (int'(last_id_q) + k) % NUM_PERIPHS;
      cand = ID_WIDTH'(idx);
      if (!next_found && req[cand]) begin
        next_found = 1'b1;
        next_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    avail       = 1'b0;
    pop         = 1'b0;
    rd          = '0;
    data_mux    = '0;
    id_out      = '0;
    busy        = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (next_found) begin
          grant_id_d  = next_id;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end

      ST_BURST: begin
        busy     = 1'b1;
        avail    = req[grant_id_q];
        data_mux = words[grant_id_q];
        id_out   = grant_id_q;
        // A pop is suppressed during reset so no word is lost from the FIFO
        // while the arbiter state is being discarded.
        pop      = tx_if.read_periph_data & avail & ~rst;
        rd[grant_id_q] = pop;

        // Drained/disabled requester and the final allowed pop both end the
        // burst through the same single transition.
        if (!avail || (pop && (burst_cnt_q == LAST_CNT))) begin
          state_d     = ST_ARB;
          last_id_d   = grant_id_q;
          burst_cnt_d = '0;
        end else if (pop) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      grant_id_q  <= '0;
      last_id_q   <= LAST_ID_RST;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign tx_if.periph_rd             = rd;
  assign tx_if.periph_data_available = avail;
  assign tx_if.out_data              = data_mux;
  assign tx_if.out_periph_id         = id_out;
  assign tx_if.busy                  = busy;

endmodule
`default_nettype wire

// File: doc/periph_tx_arbiter.md
Name: periph_tx_arbiter

Overview:
- Shares the single USB transmit path among NUM_PERIPHS peripheral TX FIFOs.
- Grants one peripheral at a time in round-robin order and holds the grant for a bounded burst.
- Presents the granted peripheral's FIFO head to the FT601 controller through a valid/pop handshake, `periph_data_available` / `read_periph_data`.
- Sits between the peripheral TX FIFOs and the FT601 controller.

Parameters:
- NUM_PERIPHS, 8: number of requesting peripherals (2..16).
- DATA_WIDTH, 32: word width, matching the FT601 bus.
- MAX_BURST, 16: maximum words popped per grant before the arbiter must re-arbitrate (1..256).
- ID_WIDTH, $clog2(NUM_PERIPHS): width of the peripheral index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- periph_enable  in  NUM_PERIPHS  per-peripheral enable mask; a disabled peripheral is never granted.
- periph_not_empty  in  NUM_PERIPHS  per-peripheral TX FIFO has data.
- periph_data  in  NUM_PERIPHS*DATA_WIDTH  FIFO head words; slice i is peripheral i (first-word-fall-through).
- periph_rd  out  NUM_PERIPHS  pop strobe to each FIFO; one-hot or zero.
- periph_data_available  out  1  granted FIFO has a valid word on out_data.
- read_periph_data  in  1  FT601 controller consumes out_data this cycle.
- out_data  out  DATA_WIDTH  data of granted peripheral; 0 when no grant.
- out_periph_id  out  ID_WIDTH  index of granted peripheral.
- busy  out  1  a grant is active.

Behaviour:
- Request vector: req[i] = periph_enable[i] & periph_not_empty[i].
- FSM states:
  - ARB: no grant.
  - BURST: grant held.
- Reset values: state=ARB, grant_id=0, last_id=NUM_PERIPHS-1 (peripheral 0 has first priority), burst_cnt=0, busy=0, periph_data_available=0, periph_rd=0, out_data=0, out_periph_id=0.
- ARB -> BURST:
  - If any req bit is set, register grant_id = first set index searching last_id+1, last_id+2, … with wrap modulo NUM_PERIPHS.
  - Set burst_cnt=0 and enter BURST on the next edge.
  - If req=0, stay in ARB.
- In BURST, combinational outputs:
  - periph_data_available = req[grant_id].
  - out_data = periph_data slice grant_id.
  - out_periph_id = grant_id.
  - busy = 1.
  - periph_rd[grant_id] = read_periph_data & periph_data_available; all other bits 0.
- read_periph_data while periph_data_available=0 is ignored: no pop, no count.
- Each pop increments burst_cnt; width is $clog2(MAX_BURST+1).
- BURST -> ARB on the next edge, with last_id=grant_id and burst_cnt cleared, when either holds:
  - a pop occurs with burst_cnt == MAX_BURST-1 (burst limit reached), or
  - req[grant_id]=0 in the current cycle (FIFO drained or peripheral disabled).
- Otherwise stay in BURST.
- Latency:
  - Request asserted in ARB: periph_data_available rises one cycle later.
  - Between bursts there is exactly one idle (ARB) cycle.
  - Peak throughput within a burst is 1 word/clock.
- Simultaneous events:
  - A pop of the final allowed word and a requester going empty in the same cycle produce a single transition to ARB.
  - New requests from other peripherals during BURST do not pre-empt the grant.
- Fairness: with all requesters active, grants cycle 0,1,…,N-1,0,…; no peripheral waits more than (NUM_PERIPHS-1) bursts.
- Mid-burst disable: periph_enable[grant_id] falling deasserts periph_data_available in the same cycle (combinational), and the FSM returns to ARB next edge.
- Reset mid-burst: all state returns to reset values on the next edge. No pop occurs in the reset cycle, because periph_rd is forced 0 while rst=1.

Test Plan:
- Single requester, 3 words: reset; enable all; only periph 2 not_empty, holding 3 words (A,B,C); read_periph_data held 1 -> available rises 1 cycle after request; out_periph_id=2; pops A,B,C on 3 consecutive cycles; periph_rd=0b00000100 each pop; then ARB, available=0.
- Burst limit, MAX_BURST=16: periph 0 holds 40 words and periph 1 holds 5; read held 1 -> grant sequence 0(16 words), 1(5), 0(16), 0(8); exactly one idle cycle between each burst.
- Round-robin fairness: all 8 periphs continuously non-empty with 20 words each; read held 1 -> grant order 0..7 then 0 again; each burst exactly 16 words.
- Backpressure: grant to periph 3; read_periph_data toggles 1,0,0,1 -> only 2 pops; burst_cnt=2; out_data stable while read=0; no periph_rd pulses during idle cycles.
- Enable mask: periph_enable=0b11111011, periph 2 and 5 non-empty -> only 5 granted. Clear enable bit 5 mid-burst -> available drops the same cycle; ARB next edge; no further pops from 5.
- Reset mid-burst: assert rst for 1 cycle during periph 4's 7th word -> no pop that cycle; busy=0, out_data=0; next grant goes to lowest requesting index starting from 0.
